// File: rtl/ipml_sfifo_pkg.sv
// Shared constants and helpers for the ipml_sfifo family.
package ipml_sfifo_pkg;

    localparam int FWFT_STD = 0;
    localparam int FWFT_ON  = 1;

    // Occupancy runs 0..2^depth_width inclusive, so it needs one extra bit.
    function automatic int count_width(input int depth_width);
        return depth_width + 1;
    endfunction

endpackage

// File: rtl/ipml_sfifo_ram.sv
// Simple dual-port memory: one write port, one read port with a resettable output register.
module ipml_sfifo_ram #(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [c_ADDR_WIDTH-1:0] wr_addr,
    input  logic [c_DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [c_ADDR_WIDTH-1:0] rd_addr,
    output logic [c_DATA_WIDTH-1:0] rd_data
);

    logic [c_DATA_WIDTH-1:0] mem [0:(1<<c_ADDR_WIDTH)-1];
    logic [c_DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The output register holds between reads; it doubles as the FWFT output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ipml_sfifo_fwft_v2_0.sv
// Single-clock FIFO with standard or first-word-fall-through read mode.
// Define IPML_SFIFO_ERR_FLAG_EN to build the sticky overflow/underflow flags.
module ipml_sfifo_fwft_v2_0
    import ipml_sfifo_pkg::*;
#(
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_DEPTH_WIDTH = 10,
    parameter int c_FWFT        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    input  logic                     rd_en,
    output logic                     rd_empty,
    output logic                     almost_empty,
    input  logic [c_DEPTH_WIDTH:0]   almost_full_th,
    input  logic [c_DEPTH_WIDTH:0]   almost_empty_th,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int CW = count_width(c_DEPTH_WIDTH);
    localparam logic [CW-1:0]            DEPTH   = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
    localparam logic [CW-1:0]            CNT_ONE = {{c_DEPTH_WIDTH{1'b0}}, 1'b1};
    localparam logic [c_DEPTH_WIDTH-1:0] PTR_ONE = {{(c_DEPTH_WIDTH-1){1'b0}}, 1'b1};

    logic [c_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            water_level_q, water_level_d, ram_count;
    logic                     rd_empty_q, rd_empty_d;
    logic                     almost_full_q, almost_full_d;
    logic                     almost_empty_q, almost_empty_d;
    logic                     out_valid_q, out_valid_d;
    logic                     wr_accept, rd_accept, ram_rd;

    assign wr_full = (water_level_q == DEPTH);

    // In FWFT mode the RAM output register is the output stage, so the RAM
    // holds one word fewer than water_level while that stage is occupied.
    always_comb begin
        wr_accept = wr_en && !wr_full;
        rd_accept = rd_en && !rd_empty_q;
        ram_count = water_level_q - (out_valid_q ? CNT_ONE : '0);

        if (c_FWFT == FWFT_ON) begin
            ram_rd      = (ram_count != '0) && (!out_valid_q || rd_accept);
            out_valid_d = ram_rd || (out_valid_q && !rd_accept);
        end else begin
            ram_rd      = rd_accept;
            out_valid_d = 1'b0;
        end

        wr_ptr_d = wr_accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = ram_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        water_level_d = water_level_q;
        if (wr_accept && !rd_accept) begin
            water_level_d = water_level_q + CNT_ONE;
        end else if (!wr_accept && rd_accept) begin
            water_level_d = water_level_q - CNT_ONE;
        end

        rd_empty_d     = (c_FWFT == FWFT_STD) ? (water_level_d == '0) : !out_valid_d;
        almost_full_d  = (water_level_d >= almost_full_th);
        almost_empty_d = (water_level_d <= almost_empty_th);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            water_level_q  <= '0;
            rd_empty_q     <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            out_valid_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            water_level_q  <= water_level_d;
            rd_empty_q     <= rd_empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign water_level  = water_level_q;
    assign rd_empty     = rd_empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;

    ipml_sfifo_ram #(
        .c_DATA_WIDTH (c_DATA_WIDTH),
        .c_ADDR_WIDTH (c_DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

`ifdef IPML_SFIFO_ERR_FLAG_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    // A new error event wins over a clear in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && wr_full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && rd_empty_q) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: doc/ipml_sfifo_fwft_v2_0.md
IPML_SFIFO_FWFT_V2_0 -- requirements
Module: ipml_sfifo_fwft_v2_0

Interface
REQ-001 The block SHALL have parameter `c_DATA_WIDTH`, default 32, giving the data width (legal 1..1152).
REQ-002 The block SHALL have parameter `c_DEPTH_WIDTH`, default 10, giving the depth width; the FIFO holds 2^c_DEPTH_WIDTH words (legal 4..16).
REQ-003 The block SHALL have parameter `c_FWFT`, default 0; 0 selects standard read mode and 1 selects first-word-fall-through.
REQ-004 The block SHALL have port `clk`, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port `rst`, input, 1 bit: reset is asynchronous and active-high.
REQ-006 The block SHALL have port `wr_data`, input, c_DATA_WIDTH bits: write data.
REQ-007 The block SHALL have port `wr_en`, input, 1 bit: write request.
REQ-008 The block SHALL have port `wr_full`, output, 1 bit: full flag.
REQ-009 The block SHALL have port `almost_full`, output, 1 bit: programmable almost-full flag.
REQ-010 The block SHALL have port `rd_data`, output, c_DATA_WIDTH bits: read data.
REQ-011 The block SHALL have port `rd_en`, input, 1 bit: read request, or pop in FWFT mode.
REQ-012 The block SHALL have port `rd_empty`, output, 1 bit: empty flag.
REQ-013 The block SHALL have port `almost_empty`, output, 1 bit: programmable almost-empty flag.
REQ-014 The block SHALL have ports `almost_full_th` and `almost_empty_th`, inputs, c_DEPTH_WIDTH+1 bits each: runtime thresholds.
REQ-015 The block SHALL have port `water_level`, output, c_DEPTH_WIDTH+1 bits: occupancy count.
REQ-016 The block SHALL have ports `overflow` and `underflow` (outputs, 1 bit each) and `err_clr` (input, 1 bit).

Function
REQ-017 A write SHALL be accepted iff wr_en=1 and wr_full=0; a read SHALL be accepted iff rd_en=1 and rd_empty=0; rejected requests SHALL change no state.
REQ-018 Write and read pointers SHALL be c_DEPTH_WIDTH bits and wrap from 2^c_DEPTH_WIDTH-1 to 0.
REQ-019 water_level SHALL be registered, range 0..2^c_DEPTH_WIDTH, and change per cycle by +1 (write only), -1 (read only) or 0 (both or neither).
REQ-020 wr_full SHALL equal (water_level == 2^c_DEPTH_WIDTH), and rd_empty SHALL be registered and follow REQ-023 and REQ-024.
REQ-021 almost_full SHALL be registered and assert when the next-cycle count >= almost_full_th; almost_empty SHALL be registered and assert when the next-cycle count <= almost_empty_th; threshold changes SHALL take effect on the next count update or at most 1 cycle later.
REQ-022 In standard mode (c_FWFT=0), rd_data SHALL update exactly 1 cycle after an accepted read and hold its value otherwise.
REQ-023 In standard mode, rd_empty SHALL equal (water_level == 0) and deassert 1 cycle after the first write into an empty FIFO.
REQ-024 In FWFT mode (c_FWFT=1), an output stage SHALL prefetch the head word; rd_data SHALL be valid whenever rd_empty=0; rd_empty SHALL deassert 2 cycles after a write into an empty FIFO; an accepted rd_en SHALL present the next word in the following cycle with no bubble while words remain.
REQ-025 In FWFT mode, water_level SHALL count the word held in the output stage, and total capacity SHALL remain 2^c_DEPTH_WIDTH.
REQ-026 A simultaneous write and read when full SHALL accept only the read; a simultaneous write and read when empty SHALL accept only the write.

Reset
REQ-027 Asserting rst SHALL immediately clear the pointers, water_level, wr_full, almost_full, rd_data, overflow and underflow to 0, and set rd_empty=1 and almost_empty=1.
REQ-028 Reset asserted mid-operation SHALL discard all contents; RAM contents need not be cleared.

Configuration
REQ-029 With macro `IPML_SFIFO_ERR_FLAG_EN` defined, overflow SHALL set (sticky) on wr_en&&wr_full, underflow SHALL set (sticky) on rd_en&&rd_empty, and err_clr SHALL clear both (a set event in the same cycle as err_clr takes priority).
REQ-030 Without the macro, overflow and underflow SHALL be tied to 0, err_clr SHALL be ignored, and no error logic SHALL be synthesised.

Structure
REQ-031 Package `ipml_sfifo_pkg` SHALL hold the mode constants (FWFT_STD=0, FWFT_ON=1) and the function for the count width (c_DEPTH_WIDTH+1).
REQ-032 A sub-module `ipml_sfifo_ram` SHALL implement the inferred 1-write/1-read registered-output simple dual-port memory; control logic SHALL stay in the top level.

Verification (c_DEPTH_WIDTH=4, c_DATA_WIDTH=8)
REQ-033 Bench: write 16 words 0x00..0x0F -> wr_full=1 after the 16th write and water_level=16; a 17th write -> data ignored and, with the macro, overflow=1.
REQ-034 Bench: with c_FWFT=1, a single write of 0xA5 into an empty FIFO -> rd_empty=0 and rd_data=0xA5 2 cycles later; rd_en -> rd_empty=1 the next cycle.
REQ-035 Bench: with the FIFO full, assert wr_en and rd_en together -> only the read is accepted, water_level=15, and the 0x10 write is lost.
REQ-036 Bench: almost_full_th=12 and almost_empty_th=2, fill from 0 -> almost_empty drops when the count reaches 3 and almost_full rises when the count reaches 12.
REQ-037 Bench: 40 writes and 40 reads interleaved at random -> data order preserved across pointer wrap and no flag glitches.
REQ-038 Bench: assert rst with 7 words stored -> rd_empty=1 and water_level=0 asynchronously; a subsequent write/read returns the new data only.
